// File: rtl/harris_pkg.sv
// Shared types and default geometry for the Harris front end.
// Sequencer states and derived counter widths.
package harris_pkg;

  localparam int W_DEF    = 480;
  localparam int H_DEF    = 360;
  localparam int WIN_DEF  = 6;
  localparam int NBUF_DEF = 7;

  localparam int OCC_W = $clog2(NBUF_DEF * W_DEF + 1);
  localparam int COL_W = $clog2(W_DEF);
  localparam int ROW_W = $clog2(H_DEF - WIN_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FLUSH  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/win_coord_counter.sv
// Row/column/window counters for the sliding-window stream.
// Tags each window with sof/eof/col_ok from the current count.
module win_coord_counter
  import harris_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int H   = H_DEF,
  parameter int WIN = WIN_DEF,
  parameter int RW  = $clog2(H - WIN + 1),
  parameter int CW  = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic          en_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          col_ok_o,
  output logic          sof_o,
  output logic          eof_o,
  output logic          done_o,
  output logic          last_o
);

  localparam int TOTAL = (H - WIN + 1) * W;
  localparam int TW    = $clog2(TOTAL + 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          adv;

  assign done_o   = (cnt_q == TW'(TOTAL));
  assign last_o   = (cnt_q == TW'(TOTAL - 1));
  assign adv      = valid_i & en_i & ~done_o;
  assign row_o    = row_q;
  assign col_o    = col_q;
  assign col_ok_o = (col_q <= CW'(W - WIN));
  assign sof_o    = valid_i & (row_q == '0) & (col_q == '0);
  assign eof_o    = valid_i & (row_q == RW'(H - WIN))
                  & (col_q == CW'(W - 1));

  // Next-state: advance raster position on each counted window
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = cnt_q + TW'(1);
      if (col_q == CW'(W - 1)) begin
        col_d = '0;
        if (row_q == RW'(H - WIN)) row_d = '0;
        else                       row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/harris_frame_sequencer.sv
// Frame controller for the 6x6 window generator: throttles input,
// tags windows, flushes the generator between frames.
module harris_frame_sequencer
  import harris_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int H    = H_DEF,
  parameter int WIN  = WIN_DEF,
  parameter int NBUF = NBUF_DEF,
  parameter int RW   = $clog2(H - WIN + 1),
  parameter int CW   = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    px_data,
  input  logic          px_valid,
  output logic          px_ready,
  output logic [7:0]    gen_pixel,
  output logic          gen_pixel_valid,
  output logic          gen_reset,
  input  logic          win_valid_in,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          win_col_ok,
  output logic          win_sof,
  output logic          win_eof,
  output logic          busy,
  output logic          frame_done,
  output logic          err
);

  localparam int CAP = NBUF * W;
  localparam int NPX = W * H;
  localparam int OW  = $clog2(CAP + 1);
  localparam int IW  = $clog2(NPX + 1);

  seq_state_t    state_q;
  logic [OW-1:0] occ_q;
  logic [IW-1:0] in_cnt_q;
  logic [7:0]    gen_pixel_q;
  logic          gen_pv_q;
  logic          gen_reset_q;
  logic          frame_done_q;
  logic          err_q;

  logic hs;
  logic win_en;
  logic win_dec;
  logic cnt_clear;
  logic win_done;
  logic win_last;
  logic frame_end;

  assign px_ready  = (state_q == STREAM) && (occ_q < OW'(CAP));
  assign hs        = px_valid & px_ready;
  assign win_en    = (state_q == STREAM) || (state_q == DRAIN);
  assign win_dec   = win_valid_in && (occ_q != '0);
  assign cnt_clear = (state_q == IDLE) && start;
  assign frame_end = win_done | (win_valid_in & win_en & win_last);

  assign busy            = (state_q != IDLE);
  assign gen_pixel       = gen_pixel_q;
  assign gen_pixel_valid = gen_pv_q;
  assign gen_reset       = gen_reset_q;
  assign frame_done      = frame_done_q;
  assign err             = err_q;

  win_coord_counter #(
    .W   (W),
    .H   (H),
    .WIN (WIN),
    .RW  (RW),
    .CW  (CW)
  ) u_coord (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .valid_i  (win_valid_in),
    .en_i     (win_en),
    .row_o    (win_row),
    .col_o    (win_col),
    .col_ok_o (win_col_ok),
    .sof_o    (win_sof),
    .eof_o    (win_eof),
    .done_o   (win_done),
    .last_o   (win_last)
  );

  // Frame FSM with occupancy tracking and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      occ_q        <= '0;
      in_cnt_q     <= '0;
      gen_pixel_q  <= '0;
      gen_pv_q     <= 1'b0;
      gen_reset_q  <= 1'b1;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      gen_pv_q     <= hs;
      gen_reset_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (hs) gen_pixel_q <= px_data;

      if (hs && !win_dec)      occ_q <= occ_q + OW'(1);
      else if (!hs && win_dec) occ_q <= occ_q - OW'(1);

      if (win_valid_in && ((state_q == IDLE) ||
          (state_q == FLUSH) || win_done))
        err_q <= 1'b1;
      if (start && (state_q != IDLE))
        err_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= STREAM;
            in_cnt_q <= '0;
            occ_q    <= '0;
          end
        end
        STREAM: begin
          if (hs) begin
            in_cnt_q <= in_cnt_q + IW'(1);
            if (in_cnt_q == IW'(NPX - 1))
              state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (frame_end) begin
            state_q      <= FLUSH;
            gen_reset_q  <= 1'b1;
            frame_done_q <= 1'b1;
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          occ_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_harris_frame_sequencer.sv
// Randomized bench for harris_frame_sequencer: small 8x8 frames
// against a window-generator model, plus backpressure at defaults.
module tb_harris_frame_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // small instance, W=8 H=8
  logic       s_start = 1'b0;
  logic [7:0] s_pd = 8'd0;
  logic       s_pv = 1'b0;
  logic       s_wv = 1'b0;
  logic       s_rdy, s_gpv, s_grst;
  logic [7:0] s_gp;
  logic [1:0] s_row;
  logic [2:0] s_col;
  logic       s_ok, s_sof, s_eof, s_busy, s_fd, s_err;

  // default-size instance
  logic       d_start = 1'b0;
  logic [7:0] d_pd = 8'd0;
  logic       d_pv = 1'b0;
  logic       d_wv = 1'b0;
  logic       d_rdy, d_gpv, d_grst;
  logic [7:0] d_gp;
  logic [8:0] d_row;
  logic [8:0] d_col;
  logic       d_ok, d_sof, d_eof, d_busy, d_fd, d_err;

  int n_chk = 0;
  int n_pass = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  harris_frame_sequencer #(.W(8), .H(8)) dut_s (
    .clk(clk), .reset(reset), .start(s_start),
    .px_data(s_pd), .px_valid(s_pv), .px_ready(s_rdy),
    .gen_pixel(s_gp), .gen_pixel_valid(s_gpv),
    .gen_reset(s_grst), .win_valid_in(s_wv),
    .win_row(s_row), .win_col(s_col), .win_col_ok(s_ok),
    .win_sof(s_sof), .win_eof(s_eof), .busy(s_busy),
    .frame_done(s_fd), .err(s_err)
  );

  harris_frame_sequencer dut_d (
    .clk(clk), .reset(reset), .start(d_start),
    .px_data(d_pd), .px_valid(d_pv), .px_ready(d_rdy),
    .gen_pixel(d_gp), .gen_pixel_valid(d_gpv),
    .gen_reset(d_grst), .win_valid_in(d_wv),
    .win_row(d_row), .win_col(d_col), .win_col_ok(d_ok),
    .win_sof(d_sof), .win_eof(d_eof), .busy(d_busy),
    .frame_done(d_fd), .err(d_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
  endtask

  // One 8x8 frame; windows emitted when the model generator holds
  // enough rows. bad_at >= 0 injects a start while busy.
  task automatic run_frame(input int bad_at);
    int acc = 0;
    int del = 0;
    int wins = 0;
    int occ = 0;
    int cyc = 0;
    bit hs;
    bit hs_p = 1'b0;
    bit rdy_e;
    bit wv;
    logic [7:0] d_p = 8'd0;
    @(negedge clk);
    s_start = 1'b1; s_pv = 1'b0; s_wv = 1'b0;
    #1;
    chk("idle_busy", int'(s_busy), 0);
    chk("idle_rdy", int'(s_rdy), 0);
    @(posedge clk);
    while (wins < 24 && cyc < 2000) begin
      @(negedge clk);
      s_start = (cyc == bad_at);
      s_pv = ($urandom_range(0, 3) != 0);
      s_pd = 8'($urandom);
      wv = (del > wins + 40) && ($urandom_range(0, 2) != 0);
      s_wv = wv;
      #1;
      rdy_e = (acc < 64) && (occ < 56);
      chk("px_ready", int'(s_rdy), int'(rdy_e));
      chk("busy", int'(s_busy), 1);
      chk("err", int'(s_err), int'(exp_err));
      chk("gen_pv", int'(s_gpv), int'(hs_p));
      if (hs_p) chk("gen_px", int'(s_gp), int'(d_p));
      if (wv) begin
        chk("row", int'(s_row), wins / 8);
        chk("col", int'(s_col), wins % 8);
        chk("col_ok", int'(s_ok), int'((wins % 8) <= 2));
        chk("sof", int'(s_sof), int'(wins == 0));
        chk("eof", int'(s_eof), int'(wins == 23));
      end else begin
        chk("sof_idle", int'(s_sof), 0);
        chk("eof_idle", int'(s_eof), 0);
      end
      chk("fd_early", int'(s_fd), 0);
      hs = s_pv & rdy_e;
      @(posedge clk);
      if (s_start) exp_err = 1'b1;
      del += int'(hs_p);
      hs_p = hs;
      if (hs) d_p = s_pd;
      acc += int'(hs);
      occ += int'(hs) - int'(wv);
      wins += int'(wv);
      cyc++;
    end
    chk("frame_timeout", wins, 24);
    @(negedge clk);
    s_start = 1'b0; s_pv = 1'b0; s_wv = 1'b0;
    #1;
    chk("flush_fd", int'(s_fd), 1);
    chk("flush_grst", int'(s_grst), 1);
    chk("flush_busy", int'(s_busy), 1);
    chk("flush_rdy", int'(s_rdy), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("post_fd", int'(s_fd), 0);
    chk("post_grst", int'(s_grst), 0);
    chk("post_busy", int'(s_busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_start = 1'b0; s_pv = 1'b0; s_wv = 1'b0;
    d_start = 1'b0; d_pv = 1'b0; d_wv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", int'(s_busy), 0);
    chk("rst_rdy", int'(s_rdy), 0);
    chk("rst_grst", int'(s_grst), 1);
    chk("rst_gpv", int'(s_gpv), 0);
    chk("rst_gp", int'(s_gp), 0);
    chk("rst_row", int'(s_row), 0);
    chk("rst_col", int'(s_col), 0);
    chk("rst_fd", int'(s_fd), 0);
    chk("rst_err", int'(s_err), 0);
    chk("rst_d_busy", int'(d_busy), 0);
    chk("rst_d_rdy", int'(d_rdy), 0);
    chk("rst_d_grst", int'(d_grst), 1);
    reset = 1'b0;
    exp_err = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    do_reset();

    // nominal frame, then back-to-back
    run_frame(-1);
    run_frame(-1);

    // mid-frame reset after 30 pixels, then a fresh frame
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      s_start = 1'b0; s_pv = 1'b1; s_pd = 8'($urandom);
      @(posedge clk);
    end
    do_reset();
    run_frame(-1);

    // start while busy: ignored, sets err
    run_frame(10);
    chk("err_sticky", int'(s_err), 1);

    // win_valid_in in IDLE sets err, which stays set
    do_reset();
    @(negedge clk);
    s_wv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_wv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("err_idle", int'(s_err), 1);
      @(posedge clk);
      @(negedge clk);
    end

    // defaults: reset after 1000 pixels
    do_reset();
    @(negedge clk);
    d_start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      d_start = 1'b0; d_pv = 1'b1; d_pd = 8'($urandom);
      #1;
      chk("d_rdy_fill", int'(d_rdy), 1);
      @(posedge clk);
    end
    do_reset();

    // backpressure: no windows, ready must fall at 3360 pixels
    @(negedge clk);
    d_start = 1'b1;
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      d_start = 1'b0; d_pv = 1'b1; d_pd = 8'($urandom);
      #1;
      if (!d_rdy) break;
      n++;
      @(posedge clk);
    end
    chk("bp_count", n, 3360);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bp_hold", int'(d_rdy), 0);
    d_wv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_wv = 1'b0;
    #1;
    chk("bp_reopen", int'(d_rdy), 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bp_one_px", int'(d_rdy), 0);

    // simultaneous handshake and window at occ 3359
    d_pv = 1'b0; d_wv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_pv = 1'b1; d_wv = 1'b1;
    #1;
    chk("sim_rdy_pre", int'(d_rdy), 1);
    @(posedge clk);
    @(negedge clk);
    d_wv = 1'b0; d_pv = 1'b0;
    #1;
    chk("sim_rdy_post", int'(d_rdy), 1);
    chk("sim_err", int'(d_err), 0);
    chk("sim_busy", int'(d_busy), 1);
    d_pv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sim_full", int'(d_rdy), 0);
    d_pv = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/harris_frame_sequencer.md
# harris_frame_sequencer

Frame-level controller for the 6×6 sliding-window generator in the Harris corner pipeline. Accepts a raster pixel stream with a valid/ready handshake. Throttles it so the seven line buffers are never overrun, and drives the generator's pixel and reset inputs. Tags every generated window with row/column coordinates, start/end-of-frame, and column validity. Between frames it flushes the generator so each frame starts from empty buffers.

## Interface
Parameters:
- W, 480: pixels per line.
- H, 360: lines per frame; legal range H ≥ WIN.
- WIN, 6: window size in lines and columns.
- NBUF, 7: line buffers in the generator.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; arms one frame; ignored unless in IDLE.
- px_data  in  8  source pixel.
- px_valid  in  1  source pixel valid.
- px_ready  out  1  sequencer accepts a pixel when px_valid & px_ready.
- gen_pixel  out  8  to generator pixel input.
- gen_pixel_valid  out  1  to generator pixel_valid input.
- gen_reset  out  1  to generator reset input.
- win_valid_in  in  1  generator window_valid.
- win_row  out  clog2(H-WIN+1)  row index of the current window.
- win_col  out  clog2(W)  column index of the current window.
- win_col_ok  out  1  high when win_col ≤ W-WIN, meaning the window does not wrap past the line end.
- win_sof  out  1  first window of the frame.
- win_eof  out  1  last window of the frame.
- busy  out  1  high when state ≠ IDLE.
- frame_done  out  1  one-cycle pulse when the frame is complete.
- err  out  1  sticky protocol error; cleared only by reset.

## Operation
- States: IDLE, STREAM, DRAIN, FLUSH.
- IDLE: px_ready=0. On start, go to STREAM and clear all counters.
- STREAM: px_ready = (occ < NBUF*W).
  - Each handshake increments in_cnt and occ.
  - When in_cnt reaches W*H, go to DRAIN; px_ready drops the cycle after the last handshake.
- DRAIN: px_ready=0. Wait until out_cnt = (H-WIN+1)*W, then go to FLUSH.
- FLUSH: gen_reset=1 for exactly one cycle. frame_done=1 in the same cycle. occ is cleared. Next state is IDLE.
- occ, the buffered-pixel count, mirrors the generator's fill logic:
  - +1 on handshake.
  - −1 on win_valid_in.
  - Unchanged when both occur in the same cycle.
  - Width clog2(NBUF*W+1); 12 bits at the defaults.
  - Never exceeds NBUF*W (3360 at the defaults).
- Window tagging, driven by win_valid_in:
  - win_col increments on each win_valid_in and wraps at W-1 to 0, incrementing win_row.
  - out_cnt increments on each win_valid_in.
  - win_row, win_col and win_col_ok are combinational from the counters and valid in the same cycle as win_valid_in.
  - win_sof = win_valid_in & row=0 & col=0.
  - win_eof = win_valid_in & row=H-WIN & col=W-1.
- err sets when:
  - win_valid_in is seen in IDLE or FLUSH; or
  - win_valid_in arrives after out_cnt has reached its terminal count; or
  - start arrives while busy. In this case start is otherwise ignored.
- Reset takes priority over every event, including mid-frame reset.
  - All counters and outputs go to 0 and state goes to IDLE.
  - gen_reset=1 while reset is high.

## Timing
- Reset values: px_ready=0, gen_pixel=0, gen_pixel_valid=0, busy=0, frame_done=0, err=0, win_* = 0, gen_reset=1. gen_reset is defined as reset | flush_pulse, both registered.
- Pixel path latency is 1 cycle: gen_pixel and gen_pixel_valid are registered from the handshake.
- occ updates on the handshake edge, not on the gen_pixel_valid edge. This gives a 1-cycle conservative margin.
- px_ready is registered-free combinational from state and occ. It does not depend on px_valid.
- start → busy=1 on the next cycle. px_ready can rise in that same cycle.
- Last window → FLUSH on the next edge → IDLE one cycle later. Minimum gap from win_eof to the next accepted start is 2 cycles.
- After FLUSH, the generator holds 5W unread pixels, which are discarded by gen_reset.

## Structure
- Shared package harris_pkg holds:
  - the W, H, WIN and NBUF defaults;
  - the state enum seq_state_t (IDLE, STREAM, DRAIN, FLUSH);
  - the derived widths OCC_W, COL_W and ROW_W.
- One sub-module, win_coord_counter: the row/column/out_cnt counters plus sof/eof/col_ok decode. It is reused by downstream Harris stages.
- Everything else is flat in harris_frame_sequencer.

## Test plan
- Nominal, with W=8, H=8 and a window-generator model:
  - start, then a continuously valid source.
  - Expect 64 handshakes and 24 windows (rows 0–2, cols 0–7).
  - win_col_ok=1 only for cols 0–2.
  - win_sof on window 0 and win_eof on window 23.
  - frame_done one cycle after win_eof; gen_reset high for exactly that cycle.
- Backpressure at the defaults:
  - Stall win_valid_in entirely.
  - px_ready must fall after exactly 3360 handshakes and occ=3360.
  - One win_valid_in pulse reopens px_ready for exactly one pixel.
- Simultaneous events at occ=3359:
  - A handshake and win_valid_in in the same cycle leave occ=3359 and px_ready=1.
- Reset mid-frame:
  - Assert reset after 1000 pixels.
  - Next cycle: busy=0, px_ready=0, gen_reset=1, counters 0.
  - A fresh start then reproduces the nominal results.
- Protocol errors:
  - win_valid_in in IDLE → err=1, and it stays set.
  - A start pulse while busy is ignored (in_cnt unaffected) and also sets err.
- Back-to-back frames at W=8, H=8:
  - Pulse start 2 cycles after frame_done.
  - Second-frame coordinates restart at 0,0 with win_sof asserted.
